// File: rtl/bus_read_sequencer_pkg.sv
// bus_read_sequencer_pkg: shared state encoding and default bus width for the bus read sequencer
package bus_read_sequencer_pkg;
    localparam int BUS_WIDTH = 64;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_TURN   = 2'd3
    } state_t;
endpackage

// File: rtl/src_onehot_dec.sv
// src_onehot_dec: source index to one-hot select, all-zero when the index names no source
module src_onehot_dec #(
    parameter int NSRC = 4,
    parameter int SRCW = 2
) (
    input  logic [SRCW-1:0] idx,
    output logic [NSRC-1:0] sel
);
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++) sel[i] = (32'(idx) == i);
    end
endmodule

// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: drives one tri-state source at a time, captures the bus, then forces a dead turnaround cycle
module bus_read_sequencer
    import bus_read_sequencer_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = 4,
    parameter int SRCW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SRCW-1:0]  req_src,
    output logic [NSRC-1:0]  drv_sel,
    input  logic [WIDTH-1:0] bus,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [SRCW-1:0]  rd_src,
    output logic             rd_err,
    output logic             busy
);
    state_t            state, state_n;
    logic [SRCW-1:0]   src, src_n;
    logic [NSRC-1:0]   dec_sel, sel_n;
    logic              accept;

    assign req_ready = (state == ST_IDLE) && !rd_valid;
    assign accept    = req_valid && req_ready;
    assign busy      = state != ST_IDLE;
    assign src_n     = accept ? req_src : src;

    src_onehot_dec #(.NSRC(NSRC), .SRCW(SRCW)) dec (.idx(src_n), .sel(dec_sel));

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   state_n = accept ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:  state_n = ST_SAMPLE;
            ST_SAMPLE: state_n = ST_TURN;
            ST_TURN:   state_n = ST_IDLE;
        endcase
        // select is registered from the next state so it never glitches and clears async
        sel_n = (state_n == ST_DRIVE || state_n == ST_SAMPLE) ? dec_sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            src      <= '0;
            drv_sel  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_src   <= '0;
            rd_err   <= 1'b0;
        end else begin
            state   <= state_n;
            drv_sel <= sel_n;
            if (accept) src <= req_src;
            if (state == ST_SAMPLE) begin
                rd_valid <= 1'b1;
                rd_data  <= |dec_sel ? bus : '0;
                rd_src   <= src;
                rd_err   <= ~|dec_sel;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bus_read_sequencer.sv
// tb_bus_read_sequencer: table-driven, directed and randomized checks of the bus read sequencer
module tb_bus_read_sequencer;
    localparam int NSRC = 4;
    localparam int SRCW = 3;
    localparam int W    = 64;

    typedef struct {
        logic            v;
        logic [SRCW-1:0] s;
        logic            r;
        logic [NSRC-1:0] sel;
        logic            rv;
        logic            rq;
        logic [W-1:0]    data;
        logic [SRCW-1:0] rs;
        logic            err;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            rd_ready = 1'b0;
    logic [SRCW-1:0] req_src = '0;
    logic            req_ready, rd_valid, rd_err, busy;
    logic [NSRC-1:0] drv_sel;
    logic [W-1:0]    rd_data;
    logic [SRCW-1:0] rd_src;
    logic [W-1:0]    q [NSRC];
    wire  [W-1:0]    bus;
    int              checks = 0;
    int              errors = 0;
    vec_t            tv [16];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NSRC; i++) begin : g_buf
        assign bus = drv_sel[i] ? q[i] : {W{1'bz}};
    end

    bus_read_sequencer #(.WIDTH(W), .NSRC(NSRC), .SRCW(SRCW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .drv_sel(drv_sel), .bus(bus), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_src(rd_src), .rd_err(rd_err),
        .busy(busy)
    );

    assert property (@(posedge clk) $onehot0(drv_sel));

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [SRCW-1:0] s, input logic r);
        req_valid = v;
        req_src   = s;
        rd_ready  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              last_acc;
        logic            m_rv, m_err;
        logic [W-1:0]    m_data;
        logic [SRCW-1:0] m_src, m_rs;
        q[0] = 64'h1111_0000_AAAA_0000;
        q[1] = 64'h2222_5555_0000_FFFF;
        q[2] = 64'hDEAD_BEEF_0123_4567;
        q[3] = 64'h3333_CAFE_F00D_7777;
        tv[0]  = '{1'b1, 3'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[1]  = '{1'b0, 3'd0, 1'b1, 4'b0100, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[2]  = '{1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 3'd2, 1'b0};
        tv[3]  = '{1'b0, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0};
        tv[4]  = '{1'b1, 3'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[5]  = '{1'b1, 3'd1, 1'b1, 4'b0001, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[6]  = '{1'b1, 3'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 64'h1111_0000_AAAA_0000, 3'd0, 1'b0};
        tv[7]  = '{1'b1, 3'd1, 1'b1, 4'b0000, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0};
        tv[8]  = '{1'b1, 3'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[9]  = '{1'b0, 3'd0, 1'b1, 4'b0010, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[10] = '{1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 64'h2222_5555_0000_FFFF, 3'd1, 1'b0};
        tv[11] = '{1'b0, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0};
        tv[12] = '{1'b1, 3'd5, 1'b0, 4'b0000, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[13] = '{1'b0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
        tv[14] = '{1'b0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 64'h0, 3'd5, 1'b1};
        tv[15] = '{1'b0, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset drv_sel", W'(drv_sel), 0);
        check("reset rd_valid", W'(rd_valid), 0);
        check("reset rd_data", rd_data, 0);
        check("reset rd_src", W'(rd_src), 0);
        check("reset rd_err", W'(rd_err), 0);
        check("reset busy", W'(busy), 0);
        check("reset req_ready", W'(req_ready), 1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            tick(tv[i].v, tv[i].s, tv[i].r);
            check($sformatf("vec%0d drv_sel", i), W'(drv_sel), W'(tv[i].sel));
            check($sformatf("vec%0d rd_valid", i), W'(rd_valid), W'(tv[i].rv));
            check($sformatf("vec%0d req_ready", i), W'(req_ready), W'(tv[i].rq));
            if (tv[i].rv) begin
                check($sformatf("vec%0d rd_data", i), rd_data, tv[i].data);
                check($sformatf("vec%0d rd_src", i), W'(rd_src), W'(tv[i].rs));
                check($sformatf("vec%0d rd_err", i), W'(rd_err), W'(tv[i].err));
            end
        end

        tick(1'b1, 3'd3, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        tick(1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("stall rd_valid", W'(rd_valid), 1);
            check("stall rd_data", rd_data, q[3]);
            check("stall rd_src", W'(rd_src), 3);
            check("stall req_ready", W'(req_ready), 0);
            tick(1'b1, 3'd2, 1'b0);
        end
        check("stall held cycle9", W'(rd_valid), 1);
        tick(1'b1, 3'd2, 1'b1);
        check("drain rd_valid", W'(rd_valid), 0);
        check("drain req_ready", W'(req_ready), 1);
        check("drain no accept", W'(busy), 0);

        tick(1'b1, 3'd1, 1'b1);
        tick(1'b0, 3'd0, 1'b1);
        check("pre-reset sample sel", W'(drv_sel), 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async reset drv_sel", W'(drv_sel), 0);
        check("async reset busy", W'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 3'd0, 1'b0);
            check("post-reset no rd_valid", W'(rd_valid), 0);
        end
        tick(1'b1, 3'd3, 1'b1);
        check("post-reset drive", W'(drv_sel), 4'b1000);
        tick(1'b0, 3'd0, 1'b1);
        check("post-reset sample", W'(drv_sel), 4'b1000);
        tick(1'b0, 3'd0, 1'b1);
        check("post-reset rd_valid", W'(rd_valid), 1);
        check("post-reset rd_data", rd_data, q[3]);
        check("post-reset rd_src", W'(rd_src), 3);
        check("post-reset turn sel", W'(drv_sel), 0);
        tick(1'b0, 3'd0, 1'b1);
        check("post-reset req_ready", W'(req_ready), 1);

        last_acc = -100;
        m_rv     = 1'b0;
        m_err    = 1'b0;
        m_data   = '0;
        m_src    = '0;
        m_rs     = '0;
        for (int k = 0; k < 10000; k++) begin
            logic            v, r, m_rq;
            logic [SRCW-1:0] s;
            logic [NSRC-1:0] exp_sel;
            v = 1'($urandom_range(0, 1));
            s = SRCW'($urandom_range(0, 7));
            r = $urandom_range(0, 9) < 7;
            for (int j = 0; j < NSRC; j++) q[j] = {$urandom, $urandom};
            m_rq = (k - 1 - last_acc > 2) && !m_rv;
            if (v && m_rq) begin
                last_acc = k;
                m_src    = s;
            end
            if (k == last_acc + 2) begin
                m_rv   = 1'b1;
                m_rs   = m_src;
                m_err  = m_src >= NSRC;
                m_data = m_err ? '0 : q[m_src[1:0]];
            end else if (r) begin
                m_rv = 1'b0;
            end
            tick(v, s, r);
            exp_sel = (k - last_acc <= 1 && m_src < NSRC) ? NSRC'(1 << m_src) : '0;
            check("rand onehot0", W'($onehot0(drv_sel)), 1);
            check("rand drv_sel", W'(drv_sel), W'(exp_sel));
            check("rand rd_valid", W'(rd_valid), W'(m_rv));
            check("rand busy", W'(busy), W'(k - last_acc <= 2));
            check("rand req_ready", W'(req_ready), W'((k - last_acc > 2) && !m_rv));
            if (m_rv) begin
                check("rand rd_data", rd_data, m_data);
                check("rand rd_src", W'(rd_src), W'(m_rs));
                check("rand rd_err", W'(rd_err), W'(m_err));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
